data_memory_arbiter: RTL and testbench

Sequences all accesses to the single-port data memory and shares it between the pipeline MEM stage and the debug/loader port. It turns each request into a fixed-latency memory transaction, stalls the pipeline until its own access completes, and guarantees the debug port cannot be starved. It sits between the MEM stage / debug unit and data_memory, and is the only block that drives data_memory's address, data and write strobe.

---
 rtl/data_memory_arbiter.sv | 148 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
// Arbiter that sequences every access to the single-port data memory, sharing it
// between the pipeline MEM stage and the debug/loader port with starvation protection.
module data_memory_arbiter #(
    parameter int PC_BITS       = 32,
    parameter int SIZE_MEMORY   = 1024,
    parameter int ACCESS_CYCLES = 2,
    parameter int STARVE_LIMIT  = 4,
    localparam int ADDR_BITS    = $clog2(SIZE_MEMORY)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read_m,
    input  logic                 mem_write_m,
    input  logic [PC_BITS-1:0]   alu_out_m,
    input  logic [PC_BITS-1:0]   write_data_m,
    output logic [PC_BITS-1:0]   read_data_m,
    output logic                 stall_m,
    input  logic                 dbg_req,
    input  logic                 dbg_we,
    input  logic [PC_BITS-1:0]   dbg_addr,
    input  logic [PC_BITS-1:0]   dbg_wdata,
    output logic [PC_BITS-1:0]   dbg_rdata,
    output logic                 dbg_done,
    output logic [ADDR_BITS-1:0] dm_addr,
    output logic [PC_BITS-1:0]   dm_wdata,
    output logic                 dm_we,
    input  logic [PC_BITS-1:0]   dm_rdata
);

    localparam int CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam int STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [STREAK_W-1:0]  streak, streak_nxt;
    logic                 owner_dbg, owner_dbg_nxt;
    logic [ADDR_BITS-1:0] lat_addr, lat_addr_nxt;
    logic [PC_BITS-1:0]   lat_wdata, lat_wdata_nxt;
    logic                 lat_we, lat_we_nxt;

    logic pipe_req;
    logic dbg_wins;
    logic grant;
    logic last_beat;

    // Only the low ADDR_BITS of each address reach the memory (wrap-around).
    logic unused_addr_hi;
    assign unused_addr_hi = ^{alu_out_m[PC_BITS-1:ADDR_BITS], dbg_addr[PC_BITS-1:ADDR_BITS]};

    assign pipe_req  = mem_read_m | mem_write_m;
    assign dbg_wins  = dbg_req & (~pipe_req | (streak == STREAK_W'(STARVE_LIMIT)));
    assign grant     = (state == IDLE) & (pipe_req | dbg_req);
    assign last_beat = (state == ACCESS) & (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            streak    <= '0;
            owner_dbg <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            streak    <= streak_nxt;
            owner_dbg <= owner_dbg_nxt;
            lat_addr  <= lat_addr_nxt;
            lat_wdata <= lat_wdata_nxt;
            lat_we    <= lat_we_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        owner_dbg_nxt = owner_dbg;
        lat_addr_nxt  = lat_addr;
        lat_wdata_nxt = lat_wdata;
        lat_we_nxt    = lat_we;
        case (state)
            IDLE: begin
                if (pipe_req | dbg_req) begin
                    state_nxt     = ACCESS;
                    cnt_nxt       = CNT_W'(ACCESS_CYCLES - 1);
                    owner_dbg_nxt = dbg_wins;
                    if (dbg_wins) begin
                        lat_addr_nxt  = dbg_addr[ADDR_BITS-1:0];
                        lat_wdata_nxt = dbg_wdata;
                        lat_we_nxt    = dbg_we;
                    end else begin
                        lat_addr_nxt  = alu_out_m[ADDR_BITS-1:0];
                        lat_wdata_nxt = write_data_m;
                        lat_we_nxt    = mem_write_m;
                    end
                end
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Streak counts pipeline wins taken while debug waits; any idle debug cycle forgives it.
    always_comb begin
        streak_nxt = streak;
        if (!dbg_req) begin
            streak_nxt = '0;
        end else if (grant & dbg_wins) begin
            streak_nxt = '0;
        end else if (grant) begin
            streak_nxt = streak + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_m <= '0;
            dbg_rdata   <= '0;
        end else if (last_beat & ~lat_we) begin
            if (owner_dbg) begin
                dbg_rdata <= dm_rdata;
            end else begin
                read_data_m <= dm_rdata;
            end
        end
    end

    assign dm_addr  = lat_addr;
    assign dm_wdata = lat_wdata;
    assign dm_we    = last_beat & lat_we;
    assign dbg_done = (state == RESP) & owner_dbg;
    assign stall_m  = ~rst & pipe_req & ~((state == RESP) & ~owner_dbg);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed scenarios plus random traffic on two
// instances (ACCESS_CYCLES 2 and 1), checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_data_memory_arbiter;

    localparam int SIZE  = 16;
    localparam int AB    = 4;
    localparam int LIMIT = 4;
    localparam int NI    = 2;

    function automatic int ac_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NI-1:0]         mem_read_m   = '0;
    logic [NI-1:0]         mem_write_m  = '0;
    logic [NI-1:0]         dbg_req      = '0;
    logic [NI-1:0]         dbg_we       = '0;
    logic [NI-1:0][31:0]   alu_out_m    = '0;
    logic [NI-1:0][31:0]   write_data_m = '0;
    logic [NI-1:0][31:0]   dbg_addr     = '0;
    logic [NI-1:0][31:0]   dbg_wdata    = '0;
    logic [NI-1:0][31:0]   read_data_m, dbg_rdata, dm_wdata, dm_rdata;
    logic [NI-1:0]         stall_m, dbg_done, dm_we;
    logic [NI-1:0][AB-1:0] dm_addr;
    logic [31:0]           dmem [NI][SIZE];

    genvar gi;
    for (gi = 0; gi < NI; gi++) begin : g_dut
        data_memory_arbiter #(
            .PC_BITS(32), .SIZE_MEMORY(SIZE),
            .ACCESS_CYCLES((gi == 0) ? 2 : 1), .STARVE_LIMIT(LIMIT)
        ) dut (
            .clk(clk), .rst(rst),
            .mem_read_m(mem_read_m[gi]), .mem_write_m(mem_write_m[gi]),
            .alu_out_m(alu_out_m[gi]), .write_data_m(write_data_m[gi]),
            .read_data_m(read_data_m[gi]), .stall_m(stall_m[gi]),
            .dbg_req(dbg_req[gi]), .dbg_we(dbg_we[gi]),
            .dbg_addr(dbg_addr[gi]), .dbg_wdata(dbg_wdata[gi]),
            .dbg_rdata(dbg_rdata[gi]), .dbg_done(dbg_done[gi]),
            .dm_addr(dm_addr[gi]), .dm_wdata(dm_wdata[gi]),
            .dm_we(dm_we[gi]), .dm_rdata(dm_rdata[gi])
        );
        assign dm_rdata[gi] = dmem[gi][dm_addr[gi]];
    end

    // Stand-in single-port data memory, cleared with the system.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                for (int a = 0; a < SIZE; a++) dmem[i][a] <= '0;
            end else if (dm_we[i]) begin
                dmem[i][dm_addr[i]] <= dm_wdata[i];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: a transaction occupies its grant cycle, ACCESS_CYCLES access
    // cycles and one response cycle; m_left counts the cycles still owed.
    int          m_left   [NI];
    bit          m_dbg    [NI];
    bit          m_we     [NI];
    int          m_addr   [NI];
    logic [31:0] m_wdata  [NI];
    logic [31:0] m_rdp    [NI];
    logic [31:0] m_rdd    [NI];
    int          m_streak [NI];
    logic [31:0] ref_mem  [NI][SIZE];
    int          we_cnt   [NI];
    int          pipe_done[NI];

    task automatic model_step(input int i);
        bit pr, dr, resp_pipe, exp_done, exp_we, gp, gd;
        pr = mem_read_m[i] | mem_write_m[i];
        dr = dbg_req[i];
        resp_pipe = 0; exp_done = 0; exp_we = 0; gp = 0; gd = 0;
        if (rst) begin
            check($sformatf("rst_stall%0d", i), 32'(stall_m[i]), 0);
            check($sformatf("rst_done%0d", i), 32'(dbg_done[i]), 0);
            check($sformatf("rst_we%0d", i), 32'(dm_we[i]), 0);
            check($sformatf("rst_addr%0d", i), 32'(dm_addr[i]), 0);
            check($sformatf("rst_wdata%0d", i), dm_wdata[i], 0);
            check($sformatf("rst_rd%0d", i), read_data_m[i], 0);
            check($sformatf("rst_dbgrd%0d", i), dbg_rdata[i], 0);
            m_left[i] = 0; m_streak[i] = 0; m_rdp[i] = 0; m_rdd[i] = 0;
            for (int a = 0; a < SIZE; a++) ref_mem[i][a] = 0;
        end else begin
            check($sformatf("rd_m%0d", i), read_data_m[i], m_rdp[i]);
            check($sformatf("dbg_rd%0d", i), dbg_rdata[i], m_rdd[i]);
            if (m_left[i] == 0) begin
                if (pr || dr) begin
                    gd = dr && (!pr || m_streak[i] == LIMIT);
                    gp = !gd;
                    m_dbg[i] = gd;
                    if (gd) begin
                        m_addr[i] = int'(dbg_addr[i] % SIZE);
                        m_we[i] = dbg_we[i];
                        m_wdata[i] = dbg_wdata[i];
                    end else begin
                        m_addr[i] = int'(alu_out_m[i] % SIZE);
                        m_we[i] = mem_write_m[i];
                        m_wdata[i] = write_data_m[i];
                    end
                    m_left[i] = ac_of(i) + 1;
                end
            end else begin
                if (m_left[i] > 1) begin
                    check($sformatf("acc_addr%0d", i), 32'(dm_addr[i]), 32'(m_addr[i]));
                    if (m_we[i]) check($sformatf("acc_wdata%0d", i), dm_wdata[i], m_wdata[i]);
                    if (m_left[i] == 2) begin
                        exp_we = m_we[i];
                        if (m_we[i]) ref_mem[i][m_addr[i]] = m_wdata[i];
                        else if (m_dbg[i]) m_rdd[i] = ref_mem[i][m_addr[i]];
                        else m_rdp[i] = ref_mem[i][m_addr[i]];
                    end
                end else begin
                    resp_pipe = !m_dbg[i];
                    exp_done = m_dbg[i];
                end
                m_left[i]--;
            end
            check($sformatf("dm_we%0d", i), 32'(dm_we[i]), 32'(exp_we));
            check($sformatf("dbg_done%0d", i), 32'(dbg_done[i]), 32'(exp_done));
            check($sformatf("stall%0d", i), 32'(stall_m[i]), 32'(pr && !resp_pipe));
            if (!dr || gd) m_streak[i] = 0;
            else if (gp) m_streak[i]++;
            if (dm_we[i]) we_cnt[i]++;
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) model_step(i);
    end

    task automatic pipe_op(input int i, input bit we, input bit both, input logic [31:0] a,
                           input logic [31:0] d, output int stalls, output logic [31:0] rd);
        int n = 0;
        mem_write_m[i] = we; mem_read_m[i] = !we || both;
        alu_out_m[i] = a; write_data_m[i] = d;
        @(negedge clk);
        while (stall_m[i] && n < 100) begin n++; @(negedge clk); end
        check($sformatf("pipe_timeout%0d", i), 32'(n >= 100), 0);
        rd = read_data_m[i];
        stalls = n;
        pipe_done[i]++;
        @(posedge clk); #1;
        mem_read_m[i] = 0; mem_write_m[i] = 0;
    endtask

    task automatic dbg_op(input int i, input bit we, input logic [31:0] a, input logic [31:0] d,
                          output int waits, output logic [31:0] rd, output int pdone);
        int n = 0;
        dbg_req[i] = 1; dbg_we[i] = we; dbg_addr[i] = a; dbg_wdata[i] = d;
        @(negedge clk);
        while (!dbg_done[i] && n < 100) begin n++; @(negedge clk); end
        check($sformatf("dbg_timeout%0d", i), 32'(n >= 100), 0);
        rd = dbg_rdata[i];
        pdone = pipe_done[i];
        waits = n;
        @(posedge clk); #1;
        dbg_req[i] = 0;
    endtask

    task automatic rand_pipe(input int i);
        int n; logic [31:0] rd;
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            pipe_op(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 40)), $urandom, n, rd);
        end
    endtask

    task automatic rand_dbg(input int i);
        int n, pd; logic [31:0] rd;
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(0, 6)) @(posedge clk);
            #1;
            dbg_op(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 40)), $urandom, n, rd, pd);
        end
    endtask

    initial begin
        int n, n2, pd, wc, p0, cnt;
        bit seen;
        logic [31:0] rd, rd2;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;

        wc = we_cnt[0];
        pipe_op(0, 1, 0, 5, 32'hDEADBEEF, n, rd);
        check("store_stall", n, 3);
        check("store_we_pulses", we_cnt[0] - wc, 1);
        pipe_op(0, 0, 0, 5, 0, n, rd);
        check("load_stall", n, 3);
        check("load_data", rd, 32'hDEADBEEF);
        @(posedge clk); #1;

        fork
            pipe_op(0, 0, 0, 5, 0, n, rd);
            dbg_op(0, 0, 5, 0, n2, rd2, pd);
        join
        check("simul_pipe_stall", n, 3);
        check("simul_dbg_wait", n2, 7);
        check("simul_dbg_data", rd2, 32'hDEADBEEF);

        p0 = pipe_done[0];
        fork
            begin
                for (int k = 0; k < 6; k++) pipe_op(0, 0, 0, 32'(k), 0, n, rd);
            end
            dbg_op(0, 0, 5, 0, n2, rd2, pd);
        join
        check("starve_pipe_before_dbg", pd - p0, 4);
        check("starve_pipe_total", pipe_done[0] - p0, 6);

        pipe_op(0, 1, 0, SIZE + 3, 32'hA5A50003, n, rd);
        dbg_op(0, 0, 3, 0, n2, rd2, pd);
        check("wrap_dbg_data", rd2, 32'hA5A50003);

        dbg_req[0] = 1; dbg_we[0] = 1; dbg_addr[0] = 7; dbg_wdata[0] = 32'h12345678;
        @(posedge clk); #1;
        dbg_req[0] = 0;
        cnt = 0; seen = 0;
        while (!seen && cnt < 20) begin @(negedge clk); seen = dbg_done[0]; cnt++; end
        check("drop_done", 32'(seen), 1);
        check("drop_latency", cnt, 3);
        @(posedge clk); #1;
        dbg_op(0, 0, 7, 0, n2, rd2, pd);
        check("drop_write_landed", rd2, 32'h12345678);

        wc = we_cnt[0];
        mem_write_m[0] = 1; alu_out_m[0] = 9; write_data_m[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1;
        #1;
        check("rst_now_stall", 32'(stall_m[0]), 0);
        check("rst_now_we", 32'(dm_we[0]), 0);
        check("rst_now_addr", 32'(dm_addr[0]), 0);
        check("rst_now_wdata", dm_wdata[0], 0);
        check("rst_now_rd", read_data_m[0], 0);
        check("rst_now_dbgrd", dbg_rdata[0], 0);
        mem_write_m[0] = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("post_rst_stall", 32'(stall_m[0]), 0);
        check("rst_no_we", we_cnt[0] - wc, 0);
        @(posedge clk); #1;
        dbg_op(0, 0, 9, 0, n2, rd2, pd);
        check("rst_aborted_write", rd2, 0);
        check("post_rst_idle_grant", n2, 3);

        pipe_op(1, 1, 0, 2, 32'h0BADCAFE, n, rd);
        check("ac1_store_stall", n, 2);
        for (int k = 0; k < 3; k++) begin
            pipe_op(1, 0, 0, 2, 0, n, rd);
            check("ac1_load_stall", n, 2);
            check("ac1_load_data", rd, 32'h0BADCAFE);
        end

        fork
            rand_pipe(0);
            rand_pipe(1);
            rand_dbg(0);
            rand_dbg(1);
        join
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
